// File: rtl/cfg_dump.sv
// cfg_dump: streams the elaborated core configuration as a framed byte sequence.
// Frame layout: magic 0x57, count 0x10, then 16 entries of {index, XLEN/8 value
// bytes LSB first}, then an XOR checksum of every byte sent before it.
// The configuration constants arrive as parameters so the enclosing build can
// pass the values it elaborated with.
module cfg_dump #(
   parameter int          XLEN                  = 64,
   parameter int          NENTRIES              = 16,
   parameter logic [63:0] MISA                  = 64'h0000_0000_0014_112D,
   parameter logic [63:0] RESET_VECTOR          = 64'h0000_0000_8000_0000,
   parameter logic [63:0] PMP_ENTRIES           = 64'd16,
   parameter logic [63:0] ITLB_ENTRIES          = 64'd32,
   parameter logic [63:0] DTLB_ENTRIES          = 64'd32,
   parameter logic [63:0] ICACHE_NUMWAYS        = 64'd4,
   parameter logic [63:0] ICACHE_WAYSIZEINBYTES = 64'd4096,
   parameter logic [63:0] ICACHE_LINELENINBITS  = 64'd512,
   parameter logic [63:0] DCACHE_NUMWAYS        = 64'd4,
   parameter logic [63:0] DCACHE_WAYSIZEINBYTES = 64'd4096,
   parameter logic [63:0] DCACHE_LINELENINBITS  = 64'd512,
   parameter logic [63:0] FLEN                  = 64'd64,
   parameter logic [63:0] DIVb                  = 64'd64,
   parameter logic [63:0] UART_PRESCALE         = 64'd0,
   parameter logic [63:0] PLIC_NUM_SRC          = 64'd10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Start,
   output logic [7:0] TxData,
   output logic       TxValid,
   input  logic       TxReady,
   output logic       Busy,
   output logic       Done
);

   localparam int                NBYTES    = XLEN / 8;
   localparam int                BW        = $clog2(NBYTES);
   localparam logic [63:0]       XLEN_V    = 64'(XLEN);
   localparam logic [BW-1:0]     LAST_BYTE = BW'(NBYTES - 1);

   typedef enum logic [2:0] {
      IDLE,
      MAGIC,
      COUNT,
      INDEX,
      VALUE,
      CSUM
   } state_t;

   // The entry table layout is fixed at 16 entries and the value packing
   // assumes a 32- or 64-bit machine; refuse to build anything else.
   generate
      if (NENTRIES != 16 || (XLEN != 32 && XLEN != 64)) begin : gBadConfig
         $error("cfg_dump: NENTRIES must be 16 and XLEN must be 32 or 64");
      end
   endgenerate

   state_t            state_q, state_d;
   logic [3:0]        entryCnt_q, entryCnt_d;
   logic [BW-1:0]     byteCnt_q, byteCnt_d;
   logic [7:0]        csum_q, csum_d;
   logic              done_q, done_d;
   logic [XLEN-1:0]   entryValue;
   logic [7:0]        valueByte;
   logic              xfer;

   assign TxValid = (state_q != IDLE);
   assign Busy    = TxValid;
   assign Done    = done_q;
   assign xfer    = TxValid & TxReady;

   // Look up the configuration value for the entry currently being sent.
   always_comb begin
      entryValue = '0;
      case (entryCnt_q)
         4'd0:  entryValue = XLEN_V[XLEN-1:0];
         4'd1:  entryValue = MISA[XLEN-1:0];
         4'd2:  entryValue = RESET_VECTOR[XLEN-1:0];
         4'd3:  entryValue = PMP_ENTRIES[XLEN-1:0];
         4'd4:  entryValue = ITLB_ENTRIES[XLEN-1:0];
         4'd5:  entryValue = DTLB_ENTRIES[XLEN-1:0];
         4'd6:  entryValue = ICACHE_NUMWAYS[XLEN-1:0];
         4'd7:  entryValue = ICACHE_WAYSIZEINBYTES[XLEN-1:0];
         4'd8:  entryValue = ICACHE_LINELENINBITS[XLEN-1:0];
         4'd9:  entryValue = DCACHE_NUMWAYS[XLEN-1:0];
         4'd10: entryValue = DCACHE_WAYSIZEINBYTES[XLEN-1:0];
         4'd11: entryValue = DCACHE_LINELENINBITS[XLEN-1:0];
         4'd12: entryValue = FLEN[XLEN-1:0];
         4'd13: entryValue = DIVb[XLEN-1:0];
         4'd14: entryValue = UART_PRESCALE[XLEN-1:0];
         4'd15: entryValue = PLIC_NUM_SRC[XLEN-1:0];
         default: entryValue = '0;
      endcase
   end

   // Pick the value byte selected by the byte counter, least significant first.
   always_comb begin
      valueByte = 8'h00;
      for (int b = 0; b < NBYTES; b++) begin
         if (byteCnt_q == BW'(b)) valueByte = entryValue[8*b +: 8];
      end
   end

   // Drive the outgoing byte purely from registered state so it holds steady
   // while the sink stalls.
   always_comb begin
      TxData = 8'h00;
      case (state_q)
         MAGIC:   TxData = 8'h57;
         COUNT:   TxData = 8'h10;
         INDEX:   TxData = {4'h0, entryCnt_q};
         VALUE:   TxData = valueByte;
         CSUM:    TxData = csum_q;
         default: TxData = 8'h00;
      endcase
   end

   // Frame sequencer: advance one field per accepted byte and fold every
   // accepted byte into the running checksum.
   always_comb begin
      state_d    = state_q;
      entryCnt_d = entryCnt_q;
      byteCnt_d  = byteCnt_q;
      csum_d     = csum_q;
      done_d     = 1'b0;
      if (xfer) csum_d = csum_q ^ TxData;
      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d    = MAGIC;
               csum_d     = 8'h00;
               entryCnt_d = 4'd0;
               byteCnt_d  = '0;
            end
         end
         MAGIC: begin
            if (xfer) state_d = COUNT;
         end
         COUNT: begin
            if (xfer) begin
               state_d    = INDEX;
               entryCnt_d = 4'd0;
            end
         end
         INDEX: begin
            if (xfer) begin
               state_d   = VALUE;
               byteCnt_d = '0;
            end
         end
         VALUE: begin
            if (xfer) begin
               if (byteCnt_q == LAST_BYTE) begin
                  if (entryCnt_q == 4'd15) begin
                     state_d = CSUM;
                  end else begin
                     entryCnt_d = entryCnt_q + 4'd1;
                     state_d    = INDEX;
                  end
               end else begin
                  byteCnt_d = byteCnt_q + BW'(1);
               end
            end
         end
         CSUM: begin
            if (xfer) begin
               state_d = IDLE;
               done_d  = 1'b1;
               csum_d  = 8'h00;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and counter registers with synchronous reset back to an idle,
   // cleared frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         entryCnt_q <= 4'd0;
         byteCnt_q  <= '0;
         csum_q     <= 8'h00;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         entryCnt_q <= entryCnt_d;
         byteCnt_q  <= byteCnt_d;
         csum_q     <= csum_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_cfg_dump.sv
// tb_cfg_dump: drives a 64-bit and a 32-bit cfg_dump with random backpressure
// and checks every output, every cycle, against a frame-level model.
module tb_cfg_dump;

   logic       clk = 1'b0;
   logic       reset;
   logic       start64, start32, ready64, ready32;
   logic [7:0] data64, data32;
   logic       valid64, valid32, busy64, busy32, done64, done32;

   // Free-running 10 ns clock shared by both designs.
   always #5 clk = ~clk;

   cfg_dump #(.XLEN(64)) dut64 (
      .clk(clk), .reset(reset), .Start(start64), .TxData(data64),
      .TxValid(valid64), .TxReady(ready64), .Busy(busy64), .Done(done64)
   );

   cfg_dump #(.XLEN(32), .DIVb(64'd32)) dut32 (
      .clk(clk), .reset(reset), .Start(start32), .TxData(data32),
      .TxValid(valid32), .TxReady(ready32), .Busy(busy32), .Done(done32)
   );

   int         checks = 0;
   int         errors = 0;
   bit         checkEnable = 1'b0;

   logic [7:0] frame [2][147];
   int         frameLen [2];
   bit         mActive [2];
   int         mIdx [2];
   bit         mDone [2];
   bit         holdPend [2];
   logic [7:0] holdData [2];
   int         xferCount [2];
   int         doneCount [2];
   logic [7:0] captured [2][147];

   task automatic cmp(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s (cycle budget expired)", name);
   endtask

   // Configuration table as the host expects to read it back (d=0: rv64gc, d=1: rv32gc).
   function automatic logic [63:0] cfgValue(input int d, input int i);
      case (i)
         0:  return (d == 0) ? 64'd64 : 64'd32;
         1:  return 64'h14112D;
         2:  return 64'h8000_0000;
         3:  return 64'd16;
         4:  return 64'd32;
         5:  return 64'd32;
         6:  return 64'd4;
         7:  return 64'd4096;
         8:  return 64'd512;
         9:  return 64'd4;
         10: return 64'd4096;
         11: return 64'd512;
         12: return 64'd64;
         13: return (d == 0) ? 64'd64 : 64'd32;
         14: return 64'd0;
         default: return 64'd10;
      endcase
   endfunction

   task automatic buildFrame(input int d, input int xlen);
      int         p;
      logic [7:0] x;
      logic [63:0] v;
      p = 0;
      frame[d][p] = 8'h57; p++;
      frame[d][p] = 8'h10; p++;
      for (int e = 0; e < 16; e++) begin
         frame[d][p] = 8'(e); p++;
         v = cfgValue(d, e);
         for (int b = 0; b < xlen / 8; b++) begin
            frame[d][p] = v[8*b +: 8]; p++;
         end
      end
      x = 8'h00;
      for (int i = 0; i < p; i++) x = x ^ frame[d][i];
      frame[d][p] = x;
      frameLen[d] = p + 1;
   endtask

   // Compare one design's outputs with the model, then step the model across
   // the coming clock edge using the inputs the design is about to sample.
   task automatic checkOutput(input int d, input logic v, input logic bsy, input logic dn,
                              input logic [7:0] data, input logic st, input logic rdy);
      logic [7:0] expData;
      expData = mActive[d] ? frame[d][mIdx[d]] : 8'h00;
      cmp($sformatf("d%0d.TxValid", d), longint'(v), longint'(mActive[d]));
      cmp($sformatf("d%0d.Busy", d), longint'(bsy), longint'(mActive[d]));
      cmp($sformatf("d%0d.Done", d), longint'(dn), longint'(mDone[d]));
      cmp($sformatf("d%0d.TxData[%0d]", d, mIdx[d]), longint'(data), longint'(expData));
      if (holdPend[d]) begin
         cmp($sformatf("d%0d.holdValid", d), longint'(v), 1);
         cmp($sformatf("d%0d.holdData", d), longint'(data), longint'(holdData[d]));
      end
      holdPend[d] = !reset && v && !rdy;
      holdData[d] = data;
      if (dn) doneCount[d]++;
      if (!reset && v && rdy && xferCount[d] < 147) begin
         captured[d][xferCount[d]] = data;
         xferCount[d]++;
      end
      if (reset) begin
         mActive[d] = 1'b0;
         mIdx[d]    = 0;
         mDone[d]   = 1'b0;
      end else begin
         mDone[d] = 1'b0;
         if (!mActive[d] && st) begin
            mActive[d]   = 1'b1;
            mIdx[d]      = 0;
            xferCount[d] = 0;
         end else if (mActive[d] && rdy) begin
            mIdx[d]++;
            if (mIdx[d] == frameLen[d]) begin
               mActive[d] = 1'b0;
               mIdx[d]    = 0;
               mDone[d]   = 1'b1;
            end
         end
      end
   endtask

   // Single compare process: sample both designs mid-cycle, away from the edge.
   always @(negedge clk) begin
      if (checkEnable) begin
         checkOutput(0, valid64, busy64, done64, data64, start64, ready64);
         checkOutput(1, valid32, busy32, done32, data32, start32, ready32);
      end
   end

   task automatic setStart(input int d, input logic v);
      if (d == 0) start64 = v; else start32 = v;
   endtask

   function automatic logic doneOut(input int d);
      return (d == 0) ? done64 : done32;
   endfunction

   // Randomize the sink readiness of the target design; the other design idles
   // with a 50% random TxReady that it must ignore.
   task automatic driveReady(input int d, input int pct);
      logic r, o;
      r = ($urandom_range(99) < pct);
      o = $urandom_range(1);
      if (d == 0) begin ready64 = r; ready32 = o; end
      else        begin ready32 = r; ready64 = o; end
   endtask

   // Run one dump on design d: optional extra Start pulses at given transfer
   // counts, an optional reset after a transfer count, and an optional
   // back-to-back Start in the Done cycle.
   task automatic applyStimulus(input int d, input int readyPct, input int startA,
                                input int startB, input int resetAfter, input int startOnDone);
      int doneBase, target, cyc;
      bit firedA, firedB, chained, aborted, timedOut;
      logic [7:0] x;
      doneBase = doneCount[d];
      target   = doneBase + 1 + startOnDone;
      cyc = 0; firedA = 0; firedB = 0; chained = 0; aborted = 0; timedOut = 0;
      @(posedge clk); #1;
      setStart(d, 1'b1);
      driveReady(d, readyPct);
      while (doneCount[d] < target && !aborted) begin
         @(posedge clk); #1;
         cyc++;
         setStart(d, 1'b0);
         reset = 1'b0;
         driveReady(d, readyPct);
         if (startA >= 0 && !firedA && xferCount[d] == startA) begin
            setStart(d, 1'b1); firedA = 1;
         end
         if (startB >= 0 && !firedB && xferCount[d] == startB) begin
            setStart(d, 1'b1); firedB = 1;
         end
         if (startOnDone != 0 && !chained && doneOut(d)) begin
            setStart(d, 1'b1); chained = 1;
         end
         if (resetAfter >= 0 && xferCount[d] == resetAfter) begin
            reset = 1'b1; aborted = 1;
         end
         if (cyc > 3000) begin
            failNow($sformatf("d%0d.frameTimeout", d));
            aborted = 1; timedOut = 1;
         end
      end
      @(posedge clk); #1;
      setStart(d, 1'b0);
      reset = 1'b0;
      if (!aborted) begin
         repeat (4) begin
            @(posedge clk); #1;
            driveReady(d, readyPct);
         end
         cmp($sformatf("d%0d.doneCount", d), longint'(doneCount[d] - doneBase),
             longint'(1 + startOnDone));
         cmp($sformatf("d%0d.byteCount", d), longint'(xferCount[d]), longint'(frameLen[d]));
         x = 8'h00;
         for (int i = 0; i < frameLen[d] - 1; i++) x = x ^ captured[d][i];
         cmp($sformatf("d%0d.checksumXor", d), longint'(captured[d][frameLen[d]-1]), longint'(x));
      end else if (!timedOut) begin
         cmp($sformatf("d%0d.validAfterReset", d), longint'(doneOut(d) | (d == 0 ? valid64 : valid32)), 0);
      end
   endtask

   // Main sequence: pin the model with literals, then walk through the dump scenarios.
   initial begin
      reset = 1'b1;
      start64 = 1'b0; start32 = 1'b0; ready64 = 1'b0; ready32 = 1'b0;
      for (int d = 0; d < 2; d++) begin
         mActive[d] = 0; mIdx[d] = 0; mDone[d] = 0; holdPend[d] = 0;
         holdData[d] = 8'h00; xferCount[d] = 0; doneCount[d] = 0;
      end
      buildFrame(0, 64);
      buildFrame(1, 32);

      cmp("model.len64", longint'(frameLen[0]), 147);
      cmp("model.len32", longint'(frameLen[1]), 83);
      cmp("model.magic", longint'(frame[0][0]), 'h57);
      cmp("model.count", longint'(frame[0][1]), 'h10);
      cmp("model.xlen64", longint'(frame[0][3]), 'h40);
      cmp("model.idx1", longint'(frame[0][11]), 'h01);
      cmp("model.misa0", longint'(frame[0][12]), 'h2D);
      cmp("model.misa1", longint'(frame[0][13]), 'h11);
      cmp("model.misa2", longint'(frame[0][14]), 'h14);
      cmp("model.xlen32", longint'({frame[1][3], frame[1][4], frame[1][5], frame[1][6]}), 'h20000000);

      @(posedge clk); #1;
      checkEnable = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         ready64 = $urandom_range(1);
         ready32 = $urandom_range(1);
      end

      $display("[TB] full dump rv64, TxReady=1");
      applyStimulus(0, 100, -1, -1, -1, 0);
      cmp("cap64.b3", longint'(captured[0][3]), 'h40);
      cmp("cap64.b10", longint'(captured[0][10]), 'h00);
      cmp("cap64.b11", longint'(captured[0][11]), 'h01);

      $display("[TB] backpressure 30 percent");
      applyStimulus(0, 30, -1, -1, -1, 0);

      $display("[TB] start while busy");
      applyStimulus(0, 100, 5, 100, -1, 0);
      applyStimulus(0, 50, 5, 146, -1, 0);

      $display("[TB] start in done cycle");
      applyStimulus(0, 100, -1, -1, -1, 1);

      $display("[TB] reset mid-frame");
      applyStimulus(0, 60, -1, -1, 40, 0);
      applyStimulus(0, 100, -1, -1, -1, 0);
      cmp("cap64.afterReset", longint'(captured[0][0]), 'h57);

      $display("[TB] rv32 dumps");
      applyStimulus(1, 100, -1, -1, -1, 0);
      cmp("cap32.b3", longint'(captured[1][3]), 'h20);
      cmp("cap32.b4", longint'(captured[1][4]), 'h00);
      applyStimulus(1, 40, 10, -1, -1, 1);

      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends even if a wait misbehaves.
   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
